// File: rtl/truthtable_capture_jdl25175_pkg.sv
// Shared types and constants for the truth-table capture block.
package truthtable_capture_jdl25175_pkg;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Number of input vectors of a 4-input function.
    localparam int unsigned NUM_VECTORS = 16;

    // Settle counter width, fixed independent of the settle time.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/truthtable_capture_jdl25175_popcount.sv
// Combinational 16-bit population count.
module popcount16_jdl25175
    import truthtable_capture_jdl25175_pkg::*;
(
    input  logic [15:0] vec,
    output logic [4:0]  count
);

    // Sum the set bits; the result fits in 0..16.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(vec[i]);
        end
    end

endmodule

// File: rtl/truthtable_capture_jdl25175.sv
// Truth-table capture: steps abcd through 0..15, waits SETTLE_CYCLES per
// vector, samples f_in into a shadow table and publishes it on completion.
// The captured table is exported on truth_table because "table" is a
// reserved word in SystemVerilog.
module truthtable_capture_jdl25175
    import truthtable_capture_jdl25175_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones_count
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_VEC    = 4'(NUM_VECTORS - 1);

    state_e             state_q,  state_d;
    logic [3:0]         abcd_q,   abcd_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [15:0]        table_q,  table_d;
    logic [4:0]         ones_q,   ones_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [15:0]        sampled;
    logic [4:0]         sampled_ones;

    // Shadow table with the current vector's sample merged in; this is what
    // gets published when the last vector is sampled.
    always_comb begin
        sampled         = shadow_q;
        sampled[abcd_q] = f_in;
    end

    popcount16_jdl25175 u_popcount (
        .vec   (sampled),
        .count (sampled_ones)
    );

    // Next-state and registered-output logic of the capture sequencer.
    always_comb begin
        state_d  = state_q;
        abcd_d   = abcd_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        table_d  = table_q;
        ones_d   = ones_q;
        unique case (state_q)
            ST_IDLE: begin
                abcd_d = 4'd0;
                if (start) begin
                    state_d  = ST_DRIVE;
                    cnt_d    = '0;
                    shadow_d = 16'h0000;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                shadow_d = sampled;
                if (abcd_q != LAST_VEC) begin
                    abcd_d  = abcd_q + 4'd1;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                    table_d = sampled;
                    ones_d  = sampled_ones;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                abcd_d  = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                abcd_d  = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            abcd_q   <= 4'd0;
            cnt_q    <= '0;
            shadow_q <= 16'h0000;
            table_q  <= 16'h0000;
            ones_q   <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            abcd_q   <= abcd_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign abcd        = abcd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign ones_count  = ones_q;

endmodule

// File: tb/tb_truthtable_capture_jdl25175.sv
// Self-checking bench: two instances (default settle time and settle time 1),
// each fed by a bench-side function table; expectations come from a simple
// timing/table model.
module tb_truthtable_capture_jdl25175;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_r [2];
    logic [15:0] tt_r    [2];
    logic        f_w     [2];
    logic [3:0]  abcd_w  [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] tab_w   [2];
    logic [4:0]  ones_w  [2];
    logic [15:0] exp_tab [2];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // The function under test is a lookup of the bench's truth table.
    assign f_w[0] = tt_r[0][abcd_w[0]];
    assign f_w[1] = tt_r[1][abcd_w[1]];

    truthtable_capture_jdl25175 dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .f_in(f_w[0]),
        .abcd(abcd_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .truth_table(tab_w[0]), .ones_count(ones_w[0])
    );

    truthtable_capture_jdl25175 #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .f_in(f_w[1]),
        .abcd(abcd_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .truth_table(tab_w[1]), .ones_count(ones_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk($sformatf("%s d%0d abcd", tag, d), 32'(abcd_w[d]), 0);
        chk($sformatf("%s d%0d busy", tag, d), 32'(busy_w[d]), 0);
        chk($sformatf("%s d%0d done", tag, d), 32'(done_w[d]), 0);
        chk($sformatf("%s d%0d table", tag, d), 32'(tab_w[d]), 32'(exp_tab[d]));
        chk($sformatf("%s d%0d ones", tag, d), 32'(ones_w[d]), $countones(exp_tab[d]));
    endtask

    // Request a run: start is raised at a falling edge, accepted on the next rise.
    task automatic kick(input int d);
        @(negedge clk);
        check_idle(d, "pre-start");
        start_r[d] = 1'b1;
    endtask

    // Follow a run from the accepting edge (edge 0) through DONE and back to
    // IDLE. Vector v is driven for s+1 cycles, so after edge k abcd = k/(s+1);
    // done appears after edge 16*(s+1). pulses re-asserts start at edges 5/47;
    // hold keeps start high, including through DONE and the following IDLE.
    task automatic track(input int d, input int s, input logic [15:0] tt,
                         input bit pulses, input bit hold);
        int          total = 16 * (s + 1);
        logic [15:0] old   = exp_tab[d];
        tt_r[d] = tt;
        for (int k = 0; k <= total + 1; k++) begin
            @(negedge clk);
            if (k < total) begin
                chk($sformatf("d%0d k%0d abcd", d, k), 32'(abcd_w[d]), k / (s + 1));
                chk($sformatf("d%0d k%0d busy", d, k), 32'(busy_w[d]), 1);
                chk($sformatf("d%0d k%0d done", d, k), 32'(done_w[d]), 0);
                chk($sformatf("d%0d k%0d table held", d, k), 32'(tab_w[d]), 32'(old));
                chk($sformatf("d%0d k%0d ones held", d, k), 32'(ones_w[d]), $countones(old));
            end else if (k == total) begin
                chk($sformatf("d%0d done pulse", d), 32'(done_w[d]), 1);
                chk($sformatf("d%0d done busy", d), 32'(busy_w[d]), 1);
                chk($sformatf("d%0d done abcd", d), 32'(abcd_w[d]), 15);
                chk($sformatf("d%0d table", d), 32'(tab_w[d]), 32'(tt));
                chk($sformatf("d%0d ones", d), 32'(ones_w[d]), $countones(tt));
            end else begin
                chk($sformatf("d%0d post busy", d), 32'(busy_w[d]), 0);
                chk($sformatf("d%0d post done", d), 32'(done_w[d]), 0);
                chk($sformatf("d%0d post abcd", d), 32'(abcd_w[d]), 0);
                chk($sformatf("d%0d post table", d), 32'(tab_w[d]), 32'(tt));
            end
            start_r[d] = hold || (pulses && (k == 4 || k == 46));
        end
        exp_tab[d] = tt;
    endtask

    initial begin
        logic [15:0] rnd;
        rst_n      = 1'b0;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        tt_r[0]    = 16'h0;
        tt_r[1]    = 16'h0;
        exp_tab[0] = 16'h0;
        exp_tab[1] = 16'h0;
        repeat (2) @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        rst_n = 1'b1;

        // f = A, with stray start pulses mid-run and at the last sample.
        kick(0); track(0, 2, 16'hFF00, 1'b1, 1'b0);
        // f = A^B^C^D, constant 1, constant 0.
        kick(0); track(0, 2, 16'h6996, 1'b0, 1'b0);
        kick(0); track(0, 2, 16'hFFFF, 1'b0, 1'b0);
        kick(0); track(0, 2, 16'h0000, 1'b0, 1'b0);
        // Settle time 1, f = C AND D.
        kick(1); track(1, 1, 16'h8888, 1'b0, 1'b0);

        // Random functions on both instances.
        for (int r = 0; r < 4; r++) begin
            rnd = 16'($urandom);
            kick(r % 2);
            track(r % 2, (r % 2 == 0) ? 2 : 1, rnd, 1'b0, 1'b0);
        end

        // start held high: second run accepted in the IDLE cycle after DONE.
        rnd = 16'($urandom);
        kick(0); track(0, 2, rnd, 1'b0, 1'b1);
        rnd = 16'($urandom);
        track(0, 2, rnd, 1'b0, 1'b0);

        // Reset mid-run: full run of ones, then a run of zeros aborted at edge 20.
        kick(0); track(0, 2, 16'hFFFF, 1'b0, 1'b0);
        kick(0);
        tt_r[0] = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
            chk($sformatf("abort k%0d abcd", k), 32'(abcd_w[0]), k / 3);
            chk($sformatf("abort k%0d table held", k), 32'(tab_w[0]), 32'hFFFF);
        end
        rst_n = 1'b0;
        start_r[0] = 1'b1;
        @(negedge clk);
        exp_tab[0] = 16'h0;
        exp_tab[1] = 16'h0;
        check_idle(0, "mid-run reset");
        check_idle(1, "mid-run reset");
        rst_n = 1'b1;
        start_r[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle(0, "after reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
